uart_command_assembler: RTL and testbench
=========================================

Name: uart_command_assembler

Overview:
- Receive-side framer for the UART command path of the GBT-IC/SCA controller. Accepts raw bytes from the UART receiver and checks the sync byte and XOR checksum.
- Assembles each valid frame into one 160-bit command word and buffers it in a show-ahead FIFO for command_resolve, through the command / command_fifo_empty / command_fifo_rd_en interface.
- This is the inbound counterpart of sca_sendback, which serialises replies onto the UART.

Parameters:
- SYNC_BYTE, 8'hAA, frame start marker.
- PAYLOAD_BYTES, 20, payload bytes per frame; the command width is 8*PAYLOAD_BYTES = 160.
- FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW = 4 commands.
- TIMEOUT_CYCLES, 400000, maximum idle clk cycles between bytes inside a frame (10 ms at 40 MHz).

Ports:
- clk  in  1  system clock (40 MHz domain).
- rst  in  1  reset.
- rx_byte  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in the same cycle.
- command  out  160  head of FIFO; first payload byte is in [159:152].
- command_fifo_empty  out  1  FIFO empty.
- command_fifo_rd_en  in  1  pops the head entry; ignored when empty.
- fifo_count  out  FIFO_AW+1  current occupancy.
- frame_ok  out  1  one-cycle pulse when a frame is written to the FIFO.
- cksum_err_cnt  out  8  saturating count of checksum failures.
- timeout_cnt  out  8  saturating count of inter-byte timeouts.
- overflow_cnt  out  8  saturating count of good frames dropped because the FIFO was full.

Behaviour:
Reset and clocking:
- Single clock. Reset is synchronous and active-high.
- rst clears the FSM to IDLE, empties the FIFO and zeroes all counters and the shift register.
- Reset values: command = 0, command_fifo_empty = 1, fifo_count = 0, frame_ok = 0, all error counters = 0.
- rst mid-frame discards the partial frame with no counter increment.

FSM states:
- IDLE: bytes other than SYNC_BYTE are discarded silently. On SYNC_BYTE, the byte index is cleared, the running XOR is cleared, and the FSM goes to PAYLOAD.
- PAYLOAD: each rx_valid shifts rx_byte into the low end of the 160-bit shift register and XORs it into the checksum. After byte PAYLOAD_BYTES-1 the FSM goes to CKSUM. SYNC_BYTE values inside the payload are plain data; there is no escaping.
- CKSUM: the next rx_valid is compared with the running XOR.
  - Match: go to PUSH.
  - Mismatch: cksum_err_cnt += 1 (saturating at 255), go to IDLE.
- PUSH: lasts one cycle.
  - FIFO not full, or full with command_fifo_rd_en asserted in the same cycle: write the entry, pulse frame_ok.
  - Otherwise: overflow_cnt += 1 (saturating).
  - Always returns to IDLE. A byte arriving during PUSH is treated as an IDLE byte.

Timeout:
- In PAYLOAD or CKSUM, a counter reloads on every rx_valid and increments otherwise.
- When it reaches TIMEOUT_CYCLES, the partial frame is discarded, timeout_cnt += 1 (saturating) and the FSM returns to IDLE.
- The counter is inactive in IDLE.

Latency:
- Checksum byte accepted in cycle N → FIFO write and frame_ok in cycle N+1.
- command_fifo_empty low and command valid from cycle N+2.

FIFO:
- Show-ahead: command always reflects the head entry and is registered.
- The pop takes effect at the clock edge. The next entry, or the held last value, appears the following cycle.
- When empty, command holds its last value.
- Simultaneous push and pop: fifo_count is unchanged and the pointers wrap modulo depth.
- Pop while empty: no effect.

Test Plan:
- Good frame: AA, 01..14, checksum 14 → command = 0x0102…14, frame_ok pulse one cycle after the checksum byte, command_fifo_empty low two cycles after, fifo_count = 1; one rd_en → empty = 1, count = 0.
- Checksum error: AA, 01..14, checksum 15 → no FIFO write, cksum_err_cnt = 1. A following good frame is accepted normally.
- Garbage, timeout and reset: leading bytes 55 3C before AA are ignored. AA + 5 bytes then silence for TIMEOUT_CYCLES (set to 100) → timeout_cnt = 1, FSM back in IDLE. rst asserted mid-payload → counters 0, FIFO empty, and the next good frame is received correctly.
- Overflow: 5 good frames with no reads (depth 4) → fifo_count = 4, overflow_cnt = 1. Reading 4 times returns frames 1–4 in order.
- Full push with pop: FIFO at 4 entries, rd_en asserted in the same cycle as PUSH → frame accepted, fifo_count stays 4, overflow_cnt unchanged, order preserved.
- Payload containing AA bytes: payload all AA, checksum 00 → accepted as a single command 0xAAAA…AA; no resynchronisation occurs.

Source files
------------

// File: rtl/uart_command_assembler_if.sv
// Byte-in / command-out bundle between the UART receiver, the framer and command_resolve.
interface uart_command_assembler_if #(
    parameter int PAYLOAD_BYTES = 20,
    parameter int FIFO_AW       = 2
);
    logic [7:0]                 rx_byte;
    logic                       rx_valid;
    logic [8*PAYLOAD_BYTES-1:0] command;
    logic                       command_fifo_empty;
    logic                       command_fifo_rd_en;
    logic [FIFO_AW:0]           fifo_count;
    logic                       frame_ok;

    modport master (
        output rx_byte, rx_valid, command_fifo_rd_en,
        input  command, command_fifo_empty, fifo_count, frame_ok
    );

    modport slave (
        input  rx_byte, rx_valid, command_fifo_rd_en,
        output command, command_fifo_empty, fifo_count, frame_ok
    );
endinterface

// File: rtl/uart_command_assembler.sv
// Frames UART bytes (sync, payload, XOR checksum) into 160-bit commands and
// queues them in a small show-ahead FIFO for command_resolve.
module uart_command_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         PAYLOAD_BYTES  = 20,
    parameter int         FIFO_AW        = 2,
    parameter int         TIMEOUT_CYCLES = 400000
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_command_assembler_if.slave  bus,
    output logic [7:0]               cksum_err_cnt,
    output logic [7:0]               timeout_cnt,
    output logic [7:0]               overflow_cnt
);

    localparam int CMD_W = 8 * PAYLOAD_BYTES;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM, PUSH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         xor_q, xor_d;
    logic [CMD_W-1:0]   shift_q, shift_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         cksum_err_q, cksum_err_d;
    logic [7:0]         timeout_q, timeout_d;
    logic [7:0]         overflow_q, overflow_d;

    logic [CMD_W-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [CMD_W-1:0]   command_q, command_d;

    logic full;
    logic wr_en;
    logic rd_en;
    logic sync_seen;

    assign full      = (count_q == FULL_COUNT);
    assign rd_en     = bus.command_fifo_rd_en && (count_q != '0);
    assign wr_en     = (state_q == PUSH) && (!full || bus.command_fifo_rd_en);
    assign sync_seen = bus.rx_valid && (bus.rx_byte == SYNC_BYTE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        xor_d       = xor_q;
        shift_d     = shift_q;
        tmo_d       = '0;
        cksum_err_d = cksum_err_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE, PUSH: begin
                if (state_q == PUSH) begin
                    state_d = IDLE;
                    if (!wr_en && overflow_q != 8'hFF) begin
                        overflow_d = overflow_q + 8'd1;
                    end
                end
                // The cycle after a push already listens for the next sync byte.
                if (sync_seen) begin
                    idx_d   = '0;
                    xor_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD, CKSUM: begin
                if (bus.rx_valid) begin
                    if (state_q == PAYLOAD) begin
                        shift_d = {shift_q[CMD_W-9:0], bus.rx_byte};
                        xor_d   = xor_q ^ bus.rx_byte;
                        if (idx_q == LAST_IDX) begin
                            state_d = CKSUM;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else if (bus.rx_byte == xor_q) begin
                        state_d = PUSH;
                    end else begin
                        state_d = IDLE;
                        if (cksum_err_q != 8'hFF) begin
                            cksum_err_d = cksum_err_q + 8'd1;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    if (timeout_q != 8'hFF) begin
                        timeout_d = timeout_q + 8'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        command_d = command_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + (FIFO_AW + 1)'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - (FIFO_AW + 1)'(1);
        end

        // Register the next head, bypassing the entry being written this cycle.
        if (count_d != '0) begin
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                command_d = shift_q;
            end else begin
                command_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            xor_q       <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            cksum_err_q <= '0;
            timeout_q   <= '0;
            overflow_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            command_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            cksum_err_q <= cksum_err_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            command_q   <= command_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign bus.command            = command_q;
    assign bus.command_fifo_empty = (count_q == '0);
    assign bus.fifo_count         = count_q;
    assign bus.frame_ok           = wr_en;
    assign cksum_err_cnt          = cksum_err_q;
    assign timeout_cnt            = timeout_q;
    assign overflow_cnt           = overflow_q;

endmodule

// File: tb/tb_uart_command_assembler.sv
// Randomised frame stimulus against a queue-based model of the framer and its 4-deep FIFO.
module tb_uart_command_assembler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cksum_err_cnt;
    logic [7:0] timeout_cnt;
    logic [7:0] overflow_cnt;

    uart_command_assembler_if #(.PAYLOAD_BYTES(20), .FIFO_AW(2)) bus ();

    uart_command_assembler #(
        .SYNC_BYTE(8'hAA),
        .PAYLOAD_BYTES(20),
        .FIFO_AW(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cksum_err_cnt(cksum_err_cnt),
        .timeout_cnt(timeout_cnt),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    logic [159:0] sb [$];
    int check_count = 0;
    int pass_count  = 0;
    int exp_cksum   = 0;
    int exp_tmo     = 0;
    int exp_ovf     = 0;
    int exp_frames  = 0;
    int seen_frames = 0;

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One byte strobe; called and returns aligned to a falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic readOne();
        bus.command_fifo_rd_en = 1'b1;
        @(negedge clk);
        bus.command_fifo_rd_en = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [159:0] randPayload();
        logic [159:0] p;
        for (int i = 0; i < 5; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    // Sends sync + payload + checksum and predicts what the framer must do with it.
    task automatic sendFrame(input logic [159:0] payload, input bit corrupt, input bit pop_in_push);
        logic [7:0] cks;
        bit         accepted;
        bit         was_empty;
        cks = 8'h00;
        for (int i = 0; i < 20; i++) cks = cks ^ payload[159-8*i -: 8];
        if (corrupt) cks = cks ^ 8'($urandom_range(1, 255));
        applyStimulus(8'hAA);
        for (int i = 0; i < 20; i++) applyStimulus(payload[159-8*i -: 8]);
        applyStimulus(cks);
        was_empty = (sb.size() == 0);
        accepted  = 1'b0;
        if (corrupt) begin
            exp_cksum++;
        end else begin
            accepted = (sb.size() < 4) || pop_in_push;
            if (accepted) begin
                sb.push_back(payload);
                exp_frames++;
            end else begin
                exp_ovf++;
            end
        end
        if (pop_in_push) bus.command_fifo_rd_en = 1'b1;
        #1;
        checkOutput("frame_ok_push_cycle", 160'(bus.frame_ok), 160'(accepted));
        if (was_empty) checkOutput("empty_during_push", 160'(bus.command_fifo_empty), 160'(1));
        @(negedge clk);
        bus.command_fifo_rd_en = 1'b0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_fifo_count"}, 160'(bus.fifo_count), 160'(sb.size()));
        checkOutput({tag, "_empty"}, 160'(bus.command_fifo_empty), 160'(sb.size() == 0));
        checkOutput({tag, "_cksum_err_cnt"}, 160'(cksum_err_cnt), 160'(exp_cksum));
        checkOutput({tag, "_timeout_cnt"}, 160'(timeout_cnt), 160'(exp_tmo));
        checkOutput({tag, "_overflow_cnt"}, 160'(overflow_cnt), 160'(exp_ovf));
    endtask

    task automatic drain();
        while (sb.size() != 0) readOne();
    endtask

    // Monitor: every accepted pop is compared with the oldest expected command.
    initial begin
        logic [159:0] exp_cmd;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.command_fifo_rd_en && !bus.command_fifo_empty) begin
                if (sb.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL fifo_head: got %h expected no entry", bus.command);
                end else begin
                    exp_cmd = sb.pop_front();
                    checkOutput("fifo_head", bus.command, exp_cmd);
                end
            end
            if (!rst && bus.frame_ok) seen_frames++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", pass_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [159:0] p;
        logic [159:0] seq_cmd;

        rst = 1'b1;
        bus.rx_byte = 8'h00;
        bus.rx_valid = 1'b0;
        bus.command_fifo_rd_en = 1'b0;
        idleCycles(3);
        rst = 1'b0;
        idleCycles(1);

        $display("[TB] reset values");
        checkOutput("reset_command", bus.command, 160'd0);
        checkOutput("reset_frame_ok", 160'(bus.frame_ok), 160'd0);
        checkCounters("reset");

        $display("[TB] good frame 01..14");
        for (int i = 0; i < 20; i++) seq_cmd[159-8*i -: 8] = 8'(i + 1);
        sendFrame(seq_cmd, 1'b0, 1'b0);
        checkOutput("latency_frame_ok_low", 160'(bus.frame_ok), 160'd0);
        checkOutput("latency_command", bus.command, seq_cmd);
        checkCounters("good1");
        readOne();
        checkCounters("good1_popped");
        readOne();
        checkOutput("pop_empty_command_held", bus.command, seq_cmd);
        checkCounters("pop_while_empty");

        $display("[TB] checksum error then good frame");
        sendFrame(seq_cmd, 1'b1, 1'b0);
        checkCounters("cksum_err");
        sendFrame(randPayload(), 1'b0, 1'b0);
        checkCounters("after_err");
        drain();

        $display("[TB] garbage and timeout");
        applyStimulus(8'h55);
        applyStimulus(8'h3C);
        applyStimulus(8'hAA);
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom));
        idleCycles(90);
        checkCounters("before_timeout");
        idleCycles(20);
        exp_tmo++;
        checkCounters("after_timeout");
        sendFrame(randPayload(), 1'b0, 1'b0);
        drain();
        checkCounters("after_timeout_frame");

        $display("[TB] reset mid-payload");
        applyStimulus(8'hAA);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        sb.delete();
        exp_cksum = 0;
        exp_tmo   = 0;
        exp_ovf   = 0;
        idleCycles(1);
        checkCounters("mid_reset");
        sendFrame(randPayload(), 1'b0, 1'b0);
        drain();

        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) sendFrame(randPayload(), 1'b0, 1'b0);
        checkCounters("overflow");
        drain();
        checkCounters("overflow_drained");

        $display("[TB] full push with pop");
        for (int i = 0; i < 4; i++) sendFrame(randPayload(), 1'b0, 1'b0);
        sendFrame(randPayload(), 1'b0, 1'b1);
        checkCounters("full_push_pop");
        drain();

        $display("[TB] all-AA payload");
        p = {20{8'hAA}};
        sendFrame(p, 1'b0, 1'b0);
        checkCounters("all_aa");
        drain();

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            sendFrame(randPayload(), ($urandom_range(0, 3) == 0), 1'b0);
            if (sb.size() != 0 && $urandom_range(0, 1) == 1) readOne();
            idleCycles($urandom_range(0, 3));
        end
        checkCounters("random");
        drain();

        checkOutput("frame_ok_total", 160'(seen_frames), 160'(exp_frames));
        checkOutput("scoreboard_drained", 160'(sb.size()), 160'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
